// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic controller and its lamp-bus monitor:
// lamp codes, phases, legal lamp patterns, fault codes and FSM states.
package traffic_pkg;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef enum logic [2:0] {
        PH_S1 = 3'd0,
        PH_S2 = 3'd1,
        PH_S3 = 3'd2,
        PH_S4 = 3'd3,
        PH_S5 = 3'd4,
        PH_S6 = 3'd5
    } phase_e;

    // Lamp buses concatenated as {M1, M2, MT, S}
    localparam logic [11:0] PAT_S1 = {GRN, GRN, RED, RED};
    localparam logic [11:0] PAT_S2 = {GRN, YEL, RED, RED};
    localparam logic [11:0] PAT_S3 = {GRN, RED, GRN, RED};
    localparam logic [11:0] PAT_S4 = {YEL, RED, YEL, RED};
    localparam logic [11:0] PAT_S5 = {RED, RED, RED, GRN};
    localparam logic [11:0] PAT_S6 = {RED, RED, RED, YEL};

    localparam logic [2:0] FLT_NONE     = 3'd0;
    localparam logic [2:0] FLT_ILLEGAL  = 3'd1;
    localparam logic [2:0] FLT_SEQUENCE = 3'd2;
    localparam logic [2:0] FLT_SHORT    = 3'd3;
    localparam logic [2:0] FLT_LONG     = 3'd4;

    typedef logic [0:0] fsm_state_t;
    localparam fsm_state_t ST_SYNC  = 1'b0;
    localparam fsm_state_t ST_TRACK = 1'b1;

    function automatic logic [2:0] next_phase(input logic [2:0] p);
        return (p == 3'(PH_S6)) ? 3'(PH_S1) : p + 3'd1;
    endfunction

endpackage

// File: rtl/traffic_phase_decoder.sv
// Maps a 12-bit lamp snapshot to its phase; anything outside the six legal
// patterns (including non-one-hot lamps) decodes as invalid with phase 0.
module traffic_phase_decoder
    import traffic_pkg::*;
(
    input  logic [11:0] i_lights,
    output logic [2:0]  o_phase,
    output logic        o_valid
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch.
        o_phase = 3'(PH_S1);
        o_valid = 1'b0;
        case (i_lights)
            PAT_S1: begin o_phase = 3'(PH_S1); o_valid = 1'b1; end
            PAT_S2: begin o_phase = 3'(PH_S2); o_valid = 1'b1; end
            PAT_S3: begin o_phase = 3'(PH_S3); o_valid = 1'b1; end
            PAT_S4: begin o_phase = 3'(PH_S4); o_valid = 1'b1; end
            PAT_S5: begin o_phase = 3'(PH_S5); o_valid = 1'b1; end
            PAT_S6: begin o_phase = 3'(PH_S6); o_valid = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive lamp-bus checker: registers the lamps, decodes the phase and checks
// conflicts, phase order and per-phase dwell; keeps a sticky first fault.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned DWELL_S1 = 8,
    parameter int unsigned DWELL_S2 = 3,
    parameter int unsigned DWELL_S3 = 6,
    parameter int unsigned DWELL_S4 = 3,
    parameter int unsigned DWELL_S5 = 4,
    parameter int unsigned DWELL_S6 = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  light_M1,
    input  logic [2:0]  light_M2,
    input  logic [2:0]  light_MT,
    input  logic [2:0]  light_S,
    input  logic        clr_fault,
    output logic [2:0]  phase,
    output logic        phase_valid,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [2:0]  fault_phase,
    output logic        cycle_done,
    output logic [15:0] cycle_cnt
);

    logic [11:0] r_lights_q;
    logic        r_sample_seen;
    logic [2:0]  r_phase;
    logic        r_phase_valid;
    fsm_state_t  r_state;
    logic [3:0]  r_dwell_cnt;
    logic        r_fault;
    logic [2:0]  r_fault_code;
    logic [2:0]  r_fault_phase;
    logic        r_cycle_done;
    logic [15:0] r_cycle_cnt;

    logic [2:0]  w_cur_phase;
    logic        w_cur_valid;
    logic        w_new_fault;
    logic [2:0]  w_new_code;
    fsm_state_t  w_next_state;
    logic [3:0]  w_next_dwell;
    logic        w_cycle_hit;

    function automatic logic [3:0] dwell_of(input logic [2:0] p);
        case (p)
            3'd0:    return 4'(DWELL_S1);
            3'd1:    return 4'(DWELL_S2);
            3'd2:    return 4'(DWELL_S3);
            3'd3:    return 4'(DWELL_S4);
            3'd4:    return 4'(DWELL_S5);
            default: return 4'(DWELL_S6);
        endcase
    endfunction

    traffic_phase_decoder u_decoder (
        .i_lights (r_lights_q),
        .o_phase  (w_cur_phase),
        .o_valid  (w_cur_valid)
    );

    // The previous sample's phase is the registered phase output itself.
    always_comb begin
        w_new_fault  = 1'b0;
        w_new_code   = FLT_NONE;
        w_next_state = r_state;
        w_next_dwell = r_dwell_cnt;
        w_cycle_hit  = 1'b0;
        if (r_sample_seen) begin
            if (!w_cur_valid) begin
                w_new_fault = 1'b1;
                w_new_code  = FLT_ILLEGAL;
            end else if (r_state == ST_SYNC) begin
                if (r_phase_valid && w_cur_phase == next_phase(r_phase)) begin
                    w_next_state = ST_TRACK;
                    w_next_dwell = 4'd1;
                end
            end else if (w_cur_phase == r_phase) begin
                if (r_dwell_cnt == dwell_of(r_phase)) begin
                    w_new_fault = 1'b1;
                    w_new_code  = FLT_LONG;
                end else if (r_dwell_cnt != 4'hF) begin
                    w_next_dwell = r_dwell_cnt + 4'd1;
                end
            end else if (w_cur_phase == next_phase(r_phase)) begin
                if (r_dwell_cnt < dwell_of(r_phase)) begin
                    w_new_fault = 1'b1;
                    w_new_code  = FLT_SHORT;
                end else begin
                    w_next_dwell = 4'd1;
                    w_cycle_hit  = (r_phase == 3'(PH_S6));
                end
            end else begin
                w_new_fault = 1'b1;
                w_new_code  = FLT_SEQUENCE;
            end
            if (w_new_fault) w_next_state = ST_SYNC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking updates so every register sees pre-edge values.
        if (!rst_n) begin
            r_lights_q    <= '0;
            r_sample_seen <= 1'b0;
            r_phase       <= '0;
            r_phase_valid <= 1'b0;
            r_state       <= ST_SYNC;
            r_dwell_cnt   <= '0;
            r_fault       <= 1'b0;
            r_fault_code  <= FLT_NONE;
            r_fault_phase <= '0;
            r_cycle_done  <= 1'b0;
            r_cycle_cnt   <= '0;
        end else begin
            r_lights_q    <= {light_M1, light_M2, light_MT, light_S};
            r_sample_seen <= 1'b1;
            r_phase       <= w_cur_phase;
            r_phase_valid <= w_cur_valid;
            r_state       <= w_next_state;
            r_dwell_cnt   <= w_next_dwell;
            r_cycle_done  <= w_cycle_hit;
            if (w_cycle_hit && r_cycle_cnt != 16'hFFFF)
                r_cycle_cnt <= r_cycle_cnt + 16'd1;
            // A fresh fault beats a simultaneous clear; otherwise first fault sticks.
            if (w_new_fault && (!r_fault || clr_fault)) begin
                r_fault       <= 1'b1;
                r_fault_code  <= w_new_code;
                r_fault_phase <= r_phase;
            end else if (clr_fault) begin
                r_fault       <= 1'b0;
                r_fault_code  <= FLT_NONE;
                r_fault_phase <= '0;
            end
        end
    end

    assign phase       = r_phase;
    assign phase_valid = r_phase_valid;
    assign fault       = r_fault;
    assign fault_code  = r_fault_code;
    assign fault_phase = r_fault_phase;
    assign cycle_done  = r_cycle_done;
    assign cycle_cnt   = r_cycle_cnt;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: expected outputs are queued as each
// lamp sample is driven and compared two edges later.
module tb_traffic_light_monitor;

    typedef struct packed {
        logic [2:0]  ph;
        logic        vld;
        logic        flt;
        logic [2:0]  code;
        logic [2:0]  fph;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [11:0] lights;
    logic        clr_fault;
    logic [2:0]  phase;
    logic        phase_valid;
    logic        fault;
    logic [2:0]  fault_code;
    logic [2:0]  fault_phase;
    logic        cycle_done;
    logic [15:0] cycle_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb[$];
    logic        clr_hold = 1'b0;
    logic        e_flt    = 1'b0;
    logic [2:0]  e_code   = 3'd0;
    logic [2:0]  e_fph    = 3'd0;
    logic [15:0] e_cnt    = 16'd0;

    localparam logic [11:0] CONFLICT = 12'b001_001_100_001;

    traffic_light_monitor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .light_M1    (lights[11:9]),
        .light_M2    (lights[8:6]),
        .light_MT    (lights[5:3]),
        .light_S     (lights[2:0]),
        .clr_fault   (clr_fault),
        .phase       (phase),
        .phase_valid (phase_valid),
        .fault       (fault),
        .fault_code  (fault_code),
        .fault_phase (fault_phase),
        .cycle_done  (cycle_done),
        .cycle_cnt   (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [11:0] pat_of(input int p);
        case (p)
            0:       return 12'b001_001_100_100;
            1:       return 12'b001_010_100_100;
            2:       return 12'b001_100_001_100;
            3:       return 12'b010_100_010_100;
            4:       return 12'b100_100_100_001;
            default: return 12'b100_100_100_010;
        endcase
    endfunction

    function automatic exp_t mk(input int p, input logic v, input logic d);
        exp_t e;
        e.ph   = 3'(p);
        e.vld  = v;
        e.flt  = e_flt;
        e.code = e_code;
        e.fph  = e_fph;
        e.done = d;
        e.cnt  = e_cnt;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic compare(input exp_t e);
        chk("phase",       16'(phase),       16'(e.ph));
        chk("phase_valid", 16'(phase_valid), 16'(e.vld));
        chk("fault",       16'(fault),       16'(e.flt));
        chk("fault_code",  16'(fault_code),  16'(e.code));
        chk("fault_phase", 16'(fault_phase), 16'(e.fph));
        chk("cycle_done",  16'(cycle_done),  16'(e.done));
        chk("cycle_cnt",   cycle_cnt,        e.cnt);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_phase"},       16'(phase),       16'd0);
        chk({tag, "_phase_valid"}, 16'(phase_valid), 16'd0);
        chk({tag, "_fault"},       16'(fault),       16'd0);
        chk({tag, "_fault_code"},  16'(fault_code),  16'd0);
        chk({tag, "_fault_phase"}, 16'(fault_phase), 16'd0);
        chk({tag, "_cycle_done"},  16'(cycle_done),  16'd0);
        chk({tag, "_cycle_cnt"},   cycle_cnt,        16'd0);
    endtask

    // Called at a falling edge; clr applies to the edge that evaluates this sample.
    task automatic step(input logic [11:0] pat, input exp_t e, input logic clr);
        if (sb.size() == 2) compare(sb.pop_front());
        lights    = pat;
        clr_fault = clr_hold;
        clr_hold  = clr;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            clr_fault = clr_hold;
            clr_hold  = 1'b0;
            compare(sb.pop_front());
            @(negedge clk);
        end
        clr_fault = 1'b0;
    endtask

    task automatic set_exp(input logic f, input logic [2:0] code, input logic [2:0] fph);
        e_flt  = f;
        e_code = code;
        e_fph  = fph;
    endtask

    task automatic hold(input int p, input int n, input logic done_first);
        for (int i = 0; i < n; i++) begin
            logic d;
            d = done_first && (i == 0);
            if (d) e_cnt = e_cnt + 16'd1;
            step(pat_of(p), mk(p, 1'b1, d), 1'b0);
        end
    endtask

    task automatic round(input logic done_first);
        hold(0, 8, done_first);
        hold(1, 3, 1'b0);
        hold(2, 6, 1'b0);
        hold(3, 3, 1'b0);
        hold(4, 4, 1'b0);
        hold(5, 3, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        clr_fault = 1'b0;
        lights    = pat_of(0);
        repeat (2) @(negedge clk);
        check_zero("reset");

        // Legal traffic: three full rounds, then entry into S1
        rst_n = 1'b1;
        round(1'b0);
        round(1'b1);
        round(1'b1);
        hold(0, 1, 1'b1);

        // Conflicting greens while tracking S1
        set_exp(1'b1, 3'd1, 3'd0);
        step(CONFLICT, mk(0, 1'b0, 1'b0), 1'b0);

        // Clear; in SYNC a long S1 hold must not be flagged
        set_exp(1'b0, 3'd0, 3'd0);
        step(pat_of(0), mk(0, 1'b1, 1'b0), 1'b1);
        hold(0, 11, 1'b0);

        // Resync on S1->S2, run round to S1 x8, then skip to S3
        hold(1, 3, 1'b0);
        hold(2, 6, 1'b0);
        hold(3, 3, 1'b0);
        hold(4, 4, 1'b0);
        hold(5, 3, 1'b0);
        hold(0, 8, 1'b1);
        set_exp(1'b1, 3'd2, 3'd0);
        step(pat_of(2), mk(2, 1'b1, 1'b0), 1'b0);

        // Clear, resync on S3->S4, come round and leave S3 after 4 samples
        set_exp(1'b0, 3'd0, 3'd0);
        step(pat_of(2), mk(2, 1'b1, 1'b0), 1'b1);
        hold(3, 3, 1'b0);
        hold(4, 4, 1'b0);
        hold(5, 3, 1'b0);
        hold(0, 8, 1'b1);
        hold(1, 3, 1'b0);
        hold(2, 4, 1'b0);
        set_exp(1'b1, 3'd3, 3'd2);
        step(pat_of(3), mk(3, 1'b1, 1'b0), 1'b0);

        // Clear, resync on S4->S5, come round and overstay S1
        set_exp(1'b0, 3'd0, 3'd0);
        step(pat_of(3), mk(3, 1'b1, 1'b0), 1'b1);
        hold(4, 4, 1'b0);
        hold(5, 3, 1'b0);
        hold(0, 8, 1'b1);
        set_exp(1'b1, 3'd4, 3'd0);
        step(pat_of(0), mk(0, 1'b1, 1'b0), 1'b0);

        // Fault still latched; resync on S1->S2, then S2->S4 with clr_fault
        hold(1, 3, 1'b0);
        set_exp(1'b1, 3'd2, 3'd1);
        step(pat_of(3), mk(3, 1'b1, 1'b0), 1'b1);

        // A later fault must not overwrite the latched one
        step(CONFLICT, mk(0, 1'b0, 1'b0), 1'b0);

        // Resync on S3->S4, then reset part way through S4
        hold(2, 1, 1'b0);
        hold(3, 3, 1'b0);
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        sb.delete();
        clr_hold  = 1'b0;
        clr_fault = 1'b0;
        set_exp(1'b0, 3'd0, 3'd0);
        e_cnt = 16'd0;
        repeat (2) @(negedge clk);

        // After reset: S4 held in SYNC, resync on S4->S5, counter restarts
        rst_n = 1'b1;
        hold(3, 5, 1'b0);
        hold(4, 4, 1'b0);
        hold(5, 3, 1'b0);
        hold(0, 1, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
